// File: rtl/adder_five_bits_pkg.sv
// Shared constants for the 5-bit adder slice.
package adder_five_bits_pkg;

  localparam int unsigned ADDER_WIDTH = 5;

endpackage : adder_five_bits_pkg

// File: rtl/adder_five_bits_full_adder.sv
// Single-bit full-adder cell used as one stage of the ripple carry chain.
module full_adder (
  output logic s,
  output logic cOut,
  input  logic a,
  input  logic b,
  input  logic cIn
);

  logic p;

  // Propagate term is shared by the sum and the carry logic.
  always_comb begin
    p    = a ^ b;
    s    = p ^ cIn;
    cOut = (a & b) | (cIn & p);
  end

endmodule : full_adder

// File: rtl/adder_five_bits.sv
// Registered WIDTH-bit ripple-carry adder with carry-in and carry-out.
// Outputs update one clock after the operands are sampled.
module adder_five_bits
  import adder_five_bits_pkg::*;
#(
  parameter int unsigned WIDTH = ADDER_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  output logic [WIDTH-1:0] sum,
  output logic             carryOut,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             carryIn
);

  logic [WIDTH:0]   carry_chain;
  logic [WIDTH-1:0] sum_d;
  logic [WIDTH-1:0] sum_q;
  logic             carry_d;
  logic             carry_q;

  assign carry_chain[0] = carryIn;

  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    full_adder u_fa (
      .s    (sum_d[i]),
      .cOut (carry_chain[i+1]),
      .a    (A[i]),
      .b    (B[i]),
      .cIn  (carry_chain[i])
    );
  end

  assign carry_d = carry_chain[WIDTH];

  // Output register; synchronous reset discards any in-flight result.
  always_ff @(posedge clk) begin
    if (reset) begin
      sum_q   <= '0;
      carry_q <= 1'b0;
    end else begin
      sum_q   <= sum_d;
      carry_q <= carry_d;
    end
  end

  assign sum      = sum_q;
  assign carryOut = carry_q;

endmodule : adder_five_bits

// File: tb/tb_adder_five_bits.sv
// Directed and exhaustive checks for adder_five_bits.
module tb_adder_five_bits;

  localparam int unsigned W = 5;

  logic         clk;
  logic         reset;
  logic [W-1:0] sum;
  logic         carryOut;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         carryIn;

  int unsigned  n_checks;
  int unsigned  n_pass;

  adder_five_bits #(.WIDTH(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .sum      (sum),
    .carryOut (carryOut),
    .A        (A),
    .B        (B),
    .carryIn  (carryIn)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compares {carryOut, sum} against an expected 6-bit value.
  task automatic check_out(input string tag, input logic [W:0] got, input logic [W:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %b_%b expected %b_%b", tag, got[W], got[W-1:0], exp[W], exp[W-1:0]);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci);
    A       = a;
    B       = b;
    carryIn = ci;
  endtask

  // Hand-computed directed vectors: {A, B, carryIn, expected {carryOut,sum}}.
  logic [W-1:0] va [6];
  logic [W-1:0] vb [6];
  logic         vc [6];
  logic [W:0]   ve [6];

  initial begin
    va[0] = 5'b11001; vb[0] = 5'b00111; vc[0] = 1'b0; ve[0] = 6'b1_00000;
    va[1] = 5'b00001; vb[1] = 5'b11111; vc[1] = 1'b0; ve[1] = 6'b1_00000;
    va[2] = 5'b00000; vb[2] = 5'b00001; vc[2] = 1'b1; ve[2] = 6'b0_00010;
    va[3] = 5'b00010; vb[3] = 5'b00010; vc[3] = 1'b0; ve[3] = 6'b0_00100;
    va[4] = 5'b10000; vb[4] = 5'b00011; vc[4] = 1'b1; ve[4] = 6'b0_10100;
    va[5] = 5'b01100; vb[5] = 5'b10000; vc[5] = 1'b0; ve[5] = 6'b0_11100;
  end

  initial begin
    logic [W:0] exp_v;
    n_checks = 0;
    n_pass   = 0;

    // Reset held for two cycles with all-ones operands.
    reset = 1'b1;
    drive(5'b11111, 5'b11111, 1'b1);
    tick();
    check_out("reset_c1", {carryOut, sum}, 6'b0_00000);
    tick();
    check_out("reset_c2", {carryOut, sum}, 6'b0_00000);
    reset = 1'b0;
    tick();
    check_out("first_after_reset", {carryOut, sum}, 6'b1_11111);

    // Output holds between edges even when operands change.
    drive(5'b00000, 5'b00000, 1'b0);
    #3;
    check_out("hold_between_edges", {carryOut, sum}, 6'b1_11111);

    // Each directed vector individually.
    for (int i = 0; i < 6; i++) begin
      drive(va[i], vb[i], vc[i]);
      tick();
      check_out($sformatf("single_%0d", i), {carryOut, sum}, ve[i]);
    end

    // Back-to-back: new vector every cycle, result exactly one edge later.
    drive(5'b00000, 5'b00000, 1'b0);
    tick();
    check_out("b2b_zero", {carryOut, sum}, 6'b0_00000);
    for (int i = 0; i < 6; i++) begin
      drive(va[i], vb[i], vc[i]);
      tick();
      check_out($sformatf("b2b_%0d", i), {carryOut, sum}, ve[i]);
    end

    // Exhaustive sweep with a reset pulse in the middle.
    for (int k = 0; k < 2048; k++) begin
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         ci;
      a  = W'(k >> 6);
      b  = W'(k >> 1);
      ci = k[0];
      exp_v = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
      if (k == 1000) begin
        reset = 1'b1;
        drive(a, b, ci);
        tick();
        check_out("midsweep_reset", {carryOut, sum}, 6'b0_00000);
        reset = 1'b0;
      end
      drive(a, b, ci);
      tick();
      check_out($sformatf("exh_a%0d_b%0d_c%0d", a, b, ci), {carryOut, sum}, exp_v);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_adder_five_bits
